// File: rtl/apb_cmd_master_if.sv
// APB bus bundle between the command master and an APB slave.
// The master drives address, control and write data; the slave answers with
// read data, ready and error status.
interface apb_cmd_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB-side command master.
// Pops {pwrite,paddr,pwdata} words from a show-ahead command fifo and runs one
// APB transfer (IDLE -> SETUP -> ACCESS) per command. Read completions push
// {err,prdata} into the response fifo; writes push nothing. A wait-state
// counter forces an error termination when the slave stalls too long, and a
// saturating counter tracks all error terminations.
module apb_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                           rclk,
    input  logic                           reset,
    input  logic [ADDR_WIDTH+DATA_WIDTH:0] cmd_rdata,
    input  logic                           cmd_empty,
    output logic                           cmd_ren,
    output logic [DATA_WIDTH:0]            rsp_wdata,
    input  logic                           rsp_full,
    output logic                           rsp_wen,
    apb_cmd_master_if.master               apb,
    output logic                           busy,
    output logic [ERR_CNT_WIDTH-1:0]       err_count
);

    // Counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit when
    // the timeout is disabled so the declaration stays legal.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic             TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic                    pwrite_q;
    logic                    psel_q;
    logic                    penable_q;
    logic [CNT_W-1:0]        wait_cnt;
    logic [ERR_CNT_WIDTH-1:0] err_count_q;

    logic                    cmd_pwrite;
    logic [ADDR_WIDTH-1:0]   cmd_paddr;
    logic [DATA_WIDTH-1:0]   cmd_pwdata;
    logic                    issue;
    logic                    timeout_hit;
    logic                    done;
    logic                    xfer_err;

    assign cmd_pwrite = cmd_rdata[ADDR_WIDTH+DATA_WIDTH];
    assign cmd_paddr  = cmd_rdata[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign cmd_pwdata = cmd_rdata[DATA_WIDTH-1:0];

    // A read only issues when the response fifo has a free slot; since this
    // block is its only writer, that slot stays reserved until completion.
    // Reset gates the pop so a command is never consumed on a reset edge.
    assign issue = !reset && (state == IDLE) && !cmd_empty && (cmd_pwrite || !rsp_full);

    assign timeout_hit = TIMEOUT_EN && !apb.pready && (wait_cnt == TIMEOUT_LAST);
    assign done        = (state == ACCESS) && (apb.pready || timeout_hit);
    assign xfer_err    = apb.pready ? apb.pslverr : 1'b1;

    assign cmd_ren   = issue;
    assign rsp_wen   = !reset && done && !pwrite_q;
    assign busy      = (state != IDLE);
    assign err_count = err_count_q;

    assign apb.paddr   = paddr_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pwdata  = pwdata_q;

    // Response word: error flag plus read data, data forced to zero on timeout.
    always_comb begin
        rsp_wdata = '0;
        if (rsp_wen) begin
            rsp_wdata = {xfer_err, (apb.pready ? apb.prdata : {DATA_WIDTH{1'b0}})};
        end
    end

    // Transfer FSM with registered APB outputs, wait counter and error count.
    always_ff @(posedge rclk) begin
        if (reset) begin
            state       <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            wait_cnt    <= '0;
            err_count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        paddr_q   <= cmd_paddr;
                        pwrite_q  <= cmd_pwrite;
                        pwdata_q  <= cmd_pwrite ? cmd_pwdata : '0;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        pwdata_q  <= '0;
                        state     <= IDLE;
                        if (xfer_err && (err_count_q != {ERR_CNT_WIDTH{1'b1}})) begin
                            err_count_q <= err_count_q + ERR_CNT_WIDTH'(1);
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master.
// A command fifo model, a configurable APB slave and a scoreboard of expected
// transfers and responses surround the DUT; everything runs from one thread,
// stepping a cycle at a time with sampling just after the falling edge.
module tb_apb_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam int EW = 8;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct {
        int            waits;
        bit            hang;
        logic [DW-1:0] rdata;
        logic          perr;
    } slv_t;

    logic            rclk = 1'b0;
    logic            reset;
    logic [AW+DW:0]  cmd_rdata;
    logic            cmd_empty;
    logic            cmd_ren;
    logic [DW:0]     rsp_wdata;
    logic            rsp_full;
    logic            rsp_wen;
    logic            busy;
    logic [EW-1:0]   err_count;

    apb_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    apb_cmd_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO),
        .ERR_CNT_WIDTH (EW)
    ) dut (
        .rclk     (rclk),
        .reset    (reset),
        .cmd_rdata(cmd_rdata),
        .cmd_empty(cmd_empty),
        .cmd_ren  (cmd_ren),
        .rsp_wdata(rsp_wdata),
        .rsp_full (rsp_full),
        .rsp_wen  (rsp_wen),
        .apb      (apb),
        .busy     (busy),
        .err_count(err_count)
    );

    always #5 rclk = ~rclk;

    cmd_t        cmd_q[$];
    cmd_t        exp_xfer[$];
    slv_t        slv_q[$];
    logic [DW:0] exp_rsp[$];

    int   checks = 0;
    int   errors = 0;
    int   exp_err = 0;
    int   acc_cycles = 0;
    int   pops = 0;
    int   rsp_count = 0;
    int   act_cycles = 0;
    logic ren_seen = 1'b0;
    logic busy_seen = 1'b0;
    cmd_t cur_x;
    slv_t cur_s;

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Present the head of the command queue as a show-ahead fifo.
    task automatic refreshFifo();
        cmd_empty = (cmd_q.size() == 0);
        if (cmd_q.size() == 0) cmd_rdata = '0;
        else cmd_rdata = {cmd_q[0].write, cmd_q[0].addr, cmd_q[0].wdata};
    endtask

    // Queue one command together with slave behaviour and expected results.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input int waits, input bit hang, input logic [DW-1:0] rdata,
                                 input logic perr, input bit expect_done);
        cmd_t c;
        cmd_t x;
        slv_t s;
        logic err;
        c.write = wr; c.addr = addr; c.wdata = wdata;
        x.write = wr; x.addr = addr; x.wdata = wr ? wdata : '0;
        s.waits = waits; s.hang = hang; s.rdata = rdata; s.perr = perr;
        cmd_q.push_back(c);
        exp_xfer.push_back(x);
        slv_q.push_back(s);
        if (expect_done) begin
            err = hang ? 1'b1 : perr;
            if (!wr) exp_rsp.push_back({err, (hang ? {DW{1'b0}} : rdata)});
            if (err && exp_err != 255) exp_err++;
        end
        refreshFifo();
    endtask

    // One clock: slave answers, monitors check, fifo pops after the edge.
    task automatic tick();
        @(negedge rclk);
        if (apb.psel && apb.penable) begin
            if (!cur_s.hang && acc_cycles == cur_s.waits) begin
                apb.pready = 1'b1; apb.prdata = cur_s.rdata; apb.pslverr = cur_s.perr;
            end else begin
                apb.pready = 1'b0; apb.prdata = 32'hBAD0_BAD0; apb.pslverr = 1'b1;
            end
            acc_cycles++;
        end else begin
            apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
            acc_cycles = 0;
        end
        #1;
        ren_seen  = cmd_ren;
        busy_seen = busy;
        if (cmd_ren) pops++;
        if (cmd_ren || busy) act_cycles++;
        if (apb.psel && !apb.penable) begin
            if (exp_xfer.size() == 0 || slv_q.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL unexpected_setup: paddr 0x%0h with nothing expected", apb.paddr);
            end else begin
                cur_x = exp_xfer.pop_front();
                cur_s = slv_q.pop_front();
                checkOutput("setup_paddr", apb.paddr, cur_x.addr);
                checkOutput("setup_pwrite", apb.pwrite, cur_x.write);
                checkOutput("setup_pwdata", apb.pwdata, cur_x.wdata);
            end
        end
        if (apb.psel && apb.penable) begin
            checkOutput("access_paddr", apb.paddr, cur_x.addr);
            checkOutput("access_pwdata", apb.pwdata, cur_x.wdata);
        end
        if (rsp_wen) begin
            rsp_count++;
            checkOutput("rsp_on_read", cur_x.write, 0);
            if (exp_rsp.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL unexpected_rsp: rsp_wdata 0x%0h with nothing expected", rsp_wdata);
            end else begin
                checkOutput("rsp_wdata", rsp_wdata, exp_rsp.pop_front());
            end
            checkOutput("access_cycles", acc_cycles, cur_s.hang ? TO : cur_s.waits + 1);
        end
        @(posedge rclk);
        #1;
        if (ren_seen && cmd_q.size() != 0) begin
            cmd_q.delete(0);
            refreshFifo();
        end
    endtask

    // Run until the fifo is drained and the master is idle, bounded.
    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((cmd_q.size() != 0 || busy_seen || ren_seen) && n < budget);
        if (cmd_q.size() != 0 || busy_seen || ren_seen) begin
            checks++; errors++;
            $display("[TB] FAIL drain_timeout: %0d cmds left, busy %0b after %0d cycles", cmd_q.size(), busy_seen, n);
        end
    endtask

    // Global time limit so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence of scenarios.
    initial begin
        int p0;
        int r0;
        int n;

        reset = 1'b1;
        rsp_full = 1'b0;
        apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
        cur_s.waits = 0; cur_s.hang = 1'b0; cur_s.rdata = '0; cur_s.perr = 1'b0;
        cur_x.write = 1'b0; cur_x.addr = '0; cur_x.wdata = '0;
        refreshFifo();

        repeat (2) tick();
        checkOutput("rst_psel", apb.psel, 0);
        checkOutput("rst_penable", apb.penable, 0);
        checkOutput("rst_pwrite", apb.pwrite, 0);
        checkOutput("rst_paddr", apb.paddr, 0);
        checkOutput("rst_pwdata", apb.pwdata, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err_count", err_count, 0);
        checkOutput("rst_rsp_wen", rsp_wen, 0);
        reset = 1'b0;
        tick();

        $display("[TB] single write");
        p0 = pops; r0 = rsp_count; act_cycles = 0;
        applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, '0, 1'b0, 1'b1);
        waitIdle(50);
        checkOutput("t1_pops", pops - p0, 1);
        checkOutput("t1_no_rsp", rsp_count - r0, 0);
        checkOutput("t1_cycles", act_cycles, 3);
        checkOutput("t1_err_count", err_count, exp_err);
        checkOutput("t1_pwdata_idle", apb.pwdata, 0);

        $display("[TB] read with 3 wait states");
        r0 = rsp_count;
        applyStimulus(1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 3, 1'b0, 32'h1234_5678, 1'b0, 1'b1);
        waitIdle(50);
        checkOutput("t2_rsp_count", rsp_count - r0, 1);
        checkOutput("t2_err_count", err_count, exp_err);

        $display("[TB] read timeout");
        r0 = rsp_count;
        applyStimulus(1'b0, 32'h0000_0030, 32'h0, 0, 1'b1, 32'h5555_AAAA, 1'b0, 1'b1);
        waitIdle(50);
        checkOutput("t3_rsp_count", rsp_count - r0, 1);
        checkOutput("t3_err_count", err_count, exp_err);

        $display("[TB] response backpressure");
        rsp_full = 1'b1;
        p0 = pops;
        applyStimulus(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 0, 1'b0, '0, 1'b0, 1'b1);
        waitIdle(50);
        checkOutput("t4_write_issued", pops - p0, 1);
        applyStimulus(1'b0, 32'h0000_0044, 32'h0, 1, 1'b0, 32'hA5A5_A5A5, 1'b0, 1'b1);
        repeat (4) tick();
        checkOutput("t4_read_held_ren", ren_seen, 0);
        checkOutput("t4_read_held_psel", apb.psel, 0);
        checkOutput("t4_read_held_pops", pops - p0, 1);
        rsp_full = 1'b0;
        tick();
        checkOutput("t4_read_issue", ren_seen, 1);
        waitIdle(50);

        $display("[TB] back-to-back with slave error");
        p0 = pops; act_cycles = 0;
        applyStimulus(1'b1, 32'h0000_0050, 32'h1111_2222, 0, 1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h0000_0054, 32'h3333_4444, 0, 1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0000_0058, 32'h0, 0, 1'b0, 32'h0BAD_CAFE, 1'b0, 1'b1);
        waitIdle(50);
        checkOutput("t5_pops", pops - p0, 3);
        checkOutput("t5_cycles", act_cycles, 9);
        checkOutput("t5_err_count", err_count, exp_err);

        $display("[TB] error counter saturation");
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1'b1, 32'h0000_1000 + 32'(i * 4), 32'(i), 0, 1'b0, '0, 1'b1, 1'b1);
        end
        waitIdle(2000);
        checkOutput("sat_err_count", err_count, 8'hFF);
        applyStimulus(1'b0, 32'h0000_2000, 32'h0, 0, 1'b0, 32'h7777_8888, 1'b1, 1'b1);
        waitIdle(50);
        checkOutput("sat_err_hold", err_count, 8'hFF);

        $display("[TB] reset during access");
        applyStimulus(1'b0, 32'h0000_0060, 32'h0, 0, 1'b1, '0, 1'b0, 1'b0);
        n = 0;
        while (!(apb.psel && apb.penable) && n < 20) begin
            tick();
            n++;
        end
        if (!(apb.psel && apb.penable)) begin
            checks++; errors++;
            $display("[TB] FAIL t6_reach_access: psel %0b penable %0b after %0d cycles", apb.psel, apb.penable, n);
        end
        reset = 1'b1;
        tick();
        checkOutput("t6_psel", apb.psel, 0);
        checkOutput("t6_penable", apb.penable, 0);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_err_count", err_count, 0);
        exp_err = 0;
        reset = 1'b0;
        tick();
        p0 = pops;
        applyStimulus(1'b1, 32'h0000_0070, 32'h0F0F_0F0F, 1, 1'b0, '0, 1'b0, 1'b1);
        waitIdle(50);
        checkOutput("t6_pops", pops - p0, 1);
        checkOutput("t6_err_after", err_count, exp_err);

        checkOutput("sb_rsp_empty", exp_rsp.size(), 0);
        checkOutput("sb_xfer_empty", exp_xfer.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
